// File: rtl/rs232_frame_timer.sv
// rs232_frame_timer: programmable bit-timing engine shared by the RS232 TX
// shifter and RX sampler. Divisor and frame length are latched when a frame
// starts, so the caller may change them freely while a frame is in flight.
module rs232_frame_timer #(
  parameter int DIV_WIDTH = 16,
  parameter int BIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] cfg_divisor,
  input  logic [BIT_WIDTH-1:0] cfg_frame_bits,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 bit_start,
  output logic                 bit_mid,
  output logic [BIT_WIDTH-1:0] bit_index,
  output logic                 frame_done,
  output logic                 cfg_error
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q;
  logic [DIV_WIDTH-1:0] baud_cnt_q;
  logic [BIT_WIDTH-1:0] bit_index_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [BIT_WIDTH-1:0] nbits_q;
  logic                 busy_q;
  logic                 bit_start_q;
  logic                 bit_mid_q;
  logic                 frame_done_q;
  logic                 cfg_error_q;

  // A divisor below 3 leaves no room for a distinct mid-bit strobe; a frame
  // needs at least a start and a stop bit.
  function automatic logic cfg_legal(input logic [DIV_WIDTH-1:0] d,
                                     input logic [BIT_WIDTH-1:0] n);
    return (d >= DIV_WIDTH'(3)) && (n >= BIT_WIDTH'(2));
  endfunction

  // Centre of a bit period of d+1 clocks. One extra bit keeps d+1 from
  // wrapping when d is all ones.
  function automatic logic [DIV_WIDTH:0] half_period(input logic [DIV_WIDTH-1:0] d);
    return ({1'b0, d} + (DIV_WIDTH+1)'(1)) >> 1;
  endfunction

  logic [DIV_WIDTH:0] cnt_inc;
  logic               mid_hit;
  logic               bit_last;
  logic               frame_last;

  // Next-count helpers; the strobe flags are computed one cycle early so the
  // strobes themselves can be registered.
  always_comb begin
    cnt_inc    = {1'b0, baud_cnt_q} + (DIV_WIDTH+1)'(1);
    mid_hit    = (cnt_inc == half_period(div_q));
    bit_last   = (baud_cnt_q == div_q);
    frame_last = (bit_index_q == (nbits_q - BIT_WIDTH'(1)));
  end

  // Frame FSM with all outputs registered; strobes default low each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      baud_cnt_q   <= '0;
      bit_index_q  <= '0;
      div_q        <= '0;
      nbits_q      <= '0;
      busy_q       <= 1'b0;
      bit_start_q  <= 1'b0;
      bit_mid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_error_q  <= 1'b0;
    end else begin
      bit_start_q  <= 1'b0;
      bit_mid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_error_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // abort outranks start here: no frame and no error report
          if (start && !abort) begin
            if (cfg_legal(cfg_divisor, cfg_frame_bits)) begin
              state_q     <= RUN;
              div_q       <= cfg_divisor;
              nbits_q     <= cfg_frame_bits;
              baud_cnt_q  <= '0;
              bit_index_q <= '0;
              busy_q      <= 1'b1;
              bit_start_q <= 1'b1;
            end else begin
              cfg_error_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_index_q <= '0;
            busy_q      <= 1'b0;
          end else if (bit_last) begin
            baud_cnt_q <= '0;
            if (frame_last) begin
              state_q      <= IDLE;
              bit_index_q  <= '0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              bit_index_q <= bit_index_q + BIT_WIDTH'(1);
              bit_start_q <= 1'b1;
            end
          end else begin
            baud_cnt_q <= cnt_inc[DIV_WIDTH-1:0];
            bit_mid_q  <= mid_hit;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign bit_start  = bit_start_q;
  assign bit_mid    = bit_mid_q;
  assign bit_index  = bit_index_q;
  assign frame_done = frame_done_q;
  assign cfg_error  = cfg_error_q;

endmodule
